// File: rtl/joy_serial_decoder.sv
// Serial joystick decoder for 74HC165-style adapter chains: drives load/shift clock, deserialises one frame per period.
// Build option JOYDEC_DEBOUNCE_EN: publish a frame only after two consecutive identical completed frames.
module joy_serial_decoder #(
  parameter int NUM_JOYS        = 2,
  parameter int BITS_PER_JOY    = 8,
  parameter int CLK_DIV         = 16,
  parameter int GAP_TICKS       = 1,
  parameter int ACTIVE_HIGH_OUT = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             joy_data_i,
  output logic                             joy_clk_o,
  output logic                             joy_load_o,
  output logic [NUM_JOYS*BITS_PER_JOY-1:0] joys_o,
  output logic                             frame_o,
  output logic                             changed_o
);

  localparam int T  = NUM_JOYS * BITS_PER_JOY;
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(T + GAP_TICKS + 1);

  localparam logic [T-1:0]  IDLE_VAL   = {T{1'(ACTIVE_HIGH_OUT == 0)}};
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_SAMPLE = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] BIT_LAST   = CW'(T - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_tick;

  logic          r_sync1;
  logic          r_sync2;
  logic [T-2:0]  r_shift;
  logic [T-1:0]  w_shift_nxt;
  logic          w_sample;
  logic          w_last;
  logic          w_update;
  logic [T-1:0]  w_raw;
  logic [T-1:0]  w_new;

  logic          r_joy_clk;
  logic          r_joy_load;
  logic [T-1:0]  r_joys;
  logic          r_frame;
  logic          r_changed;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_div_nxt = w_tick ? '0 : r_div + DW'(1);

  // Adapter data is asynchronous to clk_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= joy_data_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_tick) begin
      case (r_state)
        S_IDLE: w_state_nxt = S_LOAD;
        S_LOAD: begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end
        S_SHIFT: begin
          if (r_cnt == BIT_LAST) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Sample just before the rising shift clock so the adapter output has settled for half a period.
  assign w_sample    = (r_state == S_SHIFT) && (r_div == DIV_SAMPLE);
  assign w_last      = w_sample && (r_cnt == BIT_LAST);
  assign w_shift_nxt = {r_shift, r_sync2};

  // Serial bit k lands in joystick k/BITS_PER_JOY, MSB first.
  always_comb begin
    w_raw = '0;
    for (int k = 0; k < T; k++) begin
      w_raw[(k / BITS_PER_JOY) * BITS_PER_JOY + (BITS_PER_JOY - 1 - (k % BITS_PER_JOY))] = w_shift_nxt[T-1-k];
    end
  end

  assign w_new = w_raw ^ ~IDLE_VAL;

`ifdef JOYDEC_DEBOUNCE_EN
  logic [T-1:0] r_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prev <= IDLE_VAL;
    end else if (w_last) begin
      r_prev <= w_new;
    end
  end

  assign w_update = w_last && (w_new == r_prev);
`else
  assign w_update = w_last;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift    <= '1;
      r_joy_load <= 1'b1;
      r_joy_clk  <= 1'b0;
      r_joys     <= IDLE_VAL;
      r_frame    <= 1'b0;
      r_changed  <= 1'b0;
    end else begin
      if (w_sample) begin
        r_shift <= w_shift_nxt[T-2:0];
      end
      // Pins are computed from next state so they line up exactly with the FSM state.
      r_joy_load <= (w_state_nxt != S_LOAD);
      r_joy_clk  <= (w_state_nxt == S_SHIFT) && (w_div_nxt >= DIV_HALF);
      r_frame    <= w_last;
      r_changed  <= w_update && (w_new != r_joys);
      if (w_update) begin
        r_joys <= w_new;
      end
    end
  end

  assign joy_clk_o  = r_joy_clk;
  assign joy_load_o = r_joy_load;
  assign joys_o     = r_joys;
  assign frame_o    = r_frame;
  assign changed_o  = r_changed;

endmodule

// File: tb/tb_joy_serial_decoder.sv
// Directed bench: default decoder (2x8, div 16) plus a 1x12 active-high instance (div 8), each fed by a 74HC165 model.
module tb_joy_serial_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  // Default instance
  logic        rst0 = 1'b1;
  logic        d0;
  logic        jclk0, jload0, frame0, chg0;
  logic [15:0] joys0;
  logic [15:0] pat0 = 16'hFFFF;
  logic [15:0] sr0  = 16'hFFFF;

  // Active-high 1x12 instance
  logic        rst1 = 1'b1;
  logic        d1;
  logic        jclk1, jload1, frame1, chg1;
  logic [11:0] joys1;
  logic [11:0] pat1 = 12'hFFE;
  logic [11:0] sr1  = 12'hFFF;

  joy_serial_decoder dut0 (
    .clk_i      (clk),
    .rst_i      (rst0),
    .joy_data_i (d0),
    .joy_clk_o  (jclk0),
    .joy_load_o (jload0),
    .joys_o     (joys0),
    .frame_o    (frame0),
    .changed_o  (chg0)
  );

  joy_serial_decoder #(
    .NUM_JOYS        (1),
    .BITS_PER_JOY    (12),
    .CLK_DIV         (8),
    .GAP_TICKS       (1),
    .ACTIVE_HIGH_OUT (1)
  ) dut1 (
    .clk_i      (clk),
    .rst_i      (rst1),
    .joy_data_i (d1),
    .joy_clk_o  (jclk1),
    .joy_load_o (jload1),
    .joys_o     (joys1),
    .frame_o    (frame1),
    .changed_o  (chg1)
  );

  // Shift-register adapters: parallel load on falling load, shift on rising clock, first bit is pattern MSB.
  always @(negedge jload0 or posedge jclk0) begin
    if (!jload0) sr0 <= pat0;
    else         sr0 <= {sr0[14:0], 1'b1};
  end
  assign d0 = sr0[15];

  always @(negedge jload1 or posedge jclk1) begin
    if (!jload1) sr1 <= pat1;
    else         sr1 <= {sr1[10:0], 1'b1};
  end
  assign d1 = sr1[11];

  // Expected published value / change flag for dut0, given the raw frame value.
  logic [15:0] m_joys;
  logic [15:0] m_prev;
  logic        m_chg;

  task automatic model_frame(input logic [15:0] raw);
    logic upd;
`ifdef JOYDEC_DEBOUNCE_EN
    upd    = (raw == m_prev);
    m_prev = raw;
`else
    upd = 1'b1;
`endif
    m_chg = upd && (raw != m_joys);
    if (upd) m_joys = raw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int which, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((which == 0) ? !frame0 : !frame1) && n < budget);
  endtask

  initial begin
    int n;
    int lowcnt;
    int rises;
    int saw;
    logic prevclk;

    m_joys = 16'hFFFF;
    m_prev = 16'hFFFF;

    repeat (3) step();
    rst0 = 1'b0;

    // Reset state, cycle 0 after release
    chk("rst_load",  32'(jload0), 32'h1);
    chk("rst_clk",   32'(jclk0),  32'h0);
    chk("rst_joys",  32'(joys0),  32'hFFFF);
    chk("rst_frame", 32'(frame0), 32'h0);
    chk("rst_chg",   32'(chg0),   32'h0);

    // First frame, all buttons released
    n = 0; lowcnt = 0; rises = 0; prevclk = jclk0;
    while (!frame0 && n < 400) begin
      step();
      n++;
      if (!jload0) lowcnt++;
      if (jclk0 && !prevclk) rises++;
      prevclk = jclk0;
    end
    chk("f1_arrived", 32'(frame0), 32'h1);
    chk("f1_cycle",   32'(n),      32'd280);
    chk("f1_load_lo", 32'(lowcnt), 32'd16);
    chk("f1_clk_cnt", 32'(rises),  32'd16);
    model_frame(16'hFFFF);
    chk("f1_joys", 32'(joys0), 32'(m_joys));
    chk("f1_chg",  32'(chg0),  32'(m_chg));
    step();
    chk("f1_strobe_len", 32'(frame0), 32'h0);
    chk("f1_chg_len",    32'(chg0),   32'h0);

    // Stream 0111_1111_1111_1110: serial bit 0 -> joy0 bit 7, bit 15 -> joy1 bit 0 => 16'hFE7F
    pat0 = 16'h7FFE;
    wait_frame(0, 400, n);
    chk("f2_arrived", 32'(frame0), 32'h1);
    chk("f2_period",  32'(n),      32'd287);
    model_frame(16'hFE7F);
    chk("f2_joys", 32'(joys0), 32'(m_joys));
    chk("f2_chg",  32'(chg0),  32'(m_chg));
    step();
    chk("f2_hold", 32'(joys0), 32'(m_joys));

    // Same stream again
    wait_frame(0, 400, n);
    chk("f3_arrived", 32'(frame0), 32'h1);
    chk("f3_period",  32'(n),      32'd287);
    model_frame(16'hFE7F);
    chk("f3_joys", 32'(joys0), 32'(m_joys));
    chk("f3_chg",  32'(chg0),  32'(m_chg));

    // Reset mid-SHIFT at bit 5
    n = 0;
    while (jload0 && n < 100) begin step(); n++; end
    n = 0;
    while (!jload0 && n < 100) begin step(); n++; end
    chk("shift_entry", 32'(jload0), 32'h1);
    repeat (84) step();
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    m_joys = 16'hFFFF;
    m_prev = 16'hFFFF;
    chk("mid_rst_joys",  32'(joys0),  32'hFFFF);
    chk("mid_rst_load",  32'(jload0), 32'h1);
    chk("mid_rst_clk",   32'(jclk0),  32'h0);
    chk("mid_rst_frame", 32'(frame0), 32'h0);
    n = 0; saw = 0;
    while (jload0 && n < 100) begin
      step();
      n++;
      if (frame0) saw++;
    end
    chk("mid_rst_load_at", 32'(n),   32'd16);
    chk("mid_rst_noframe", 32'(saw), 32'd0);
    wait_frame(0, 400, n);
    chk("post_rst_arrived", 32'(frame0), 32'h1);
    chk("post_rst_cycle",   32'(n),      32'd264);
    model_frame(16'hFE7F);
    chk("post_rst_joys", 32'(joys0), 32'(m_joys));
    chk("post_rst_chg",  32'(chg0),  32'(m_chg));

    // Raw frames FFFE, FFFF, FFFE, FFFE (stream FEFF puts the 0 on joy0 bit 0)
    pat0 = 16'hFEFF;
    wait_frame(0, 400, n);
    chk("db1_arrived", 32'(frame0), 32'h1);
    model_frame(16'hFFFE);
    chk("db1_joys", 32'(joys0), 32'(m_joys));
    chk("db1_chg",  32'(chg0),  32'(m_chg));
    pat0 = 16'hFFFF;
    wait_frame(0, 400, n);
    chk("db2_arrived", 32'(frame0), 32'h1);
    model_frame(16'hFFFF);
    chk("db2_joys", 32'(joys0), 32'(m_joys));
    chk("db2_chg",  32'(chg0),  32'(m_chg));
    pat0 = 16'hFEFF;
    wait_frame(0, 400, n);
    chk("db3_arrived", 32'(frame0), 32'h1);
    model_frame(16'hFFFE);
    chk("db3_joys", 32'(joys0), 32'(m_joys));
    chk("db3_chg",  32'(chg0),  32'(m_chg));
    wait_frame(0, 400, n);
    chk("db4_arrived", 32'(frame0), 32'h1);
    model_frame(16'hFFFE);
    chk("db4_joys",  32'(joys0), 32'(m_joys));
    chk("db4_chg",   32'(chg0),  32'(m_chg));
    chk("db4_final", 32'(joys0), 32'hFFFE);

    // Active-high 1x12 instance, stream 12'hFFE
    rst1 = 1'b0;
    chk("ah_rst_joys", 32'(joys1),  32'h000);
    chk("ah_rst_load", 32'(jload1), 32'h1);
    chk("ah_rst_clk",  32'(jclk1),  32'h0);
    wait_frame(1, 200, n);
    chk("ah_f1_arrived", 32'(frame1), 32'h1);
    chk("ah_f1_cycle",   32'(n),      32'd108);
`ifdef JOYDEC_DEBOUNCE_EN
    chk("ah_f1_joys", 32'(joys1), 32'h000);
    chk("ah_f1_chg",  32'(chg1),  32'h0);
`else
    chk("ah_f1_joys", 32'(joys1), 32'h001);
    chk("ah_f1_chg",  32'(chg1),  32'h1);
`endif
    step();
    chk("ah_f1_strobe_len", 32'(frame1), 32'h0);
    wait_frame(1, 200, n);
    chk("ah_f2_arrived", 32'(frame1), 32'h1);
    chk("ah_f2_period",  32'(n),      32'd111);
    chk("ah_f2_joys",    32'(joys1),  32'h001);
`ifdef JOYDEC_DEBOUNCE_EN
    chk("ah_f2_chg", 32'(chg1), 32'h1);
`else
    chk("ah_f2_chg", 32'(chg1), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
